capture_segment_ctrl: RTL and testbench
=======================================

CAPTURE_SEGMENT_CTRL -- requirements
Module: capture_segment_ctrl

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 72, meaning captured sample width in bits.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 12, meaning log2 of total buffer depth.
REQ-003 The block SHALL take parameter NUM_SEGMENTS, default 4, meaning segments per capture; power of two, at most 2^(ADDR_WIDTH-1).
REQ-004 Ports SHALL be, in this order:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high
- clk_enable  in  1  sample qualifier
- start  in  1  arm-request pulse
- abort  in  1  cancel capture
- pretrig_depth  in  ADDR_WIDTH  requested pre-trigger samples
- trigger  in  1  trigger condition
- data_in  in  DATA_WIDTH  sample
- rd_addr  in  ADDR_WIDTH  buffer read address
- rd_seg  in  log2(NUM_SEGMENTS) (min 1)  trigger-address query
- ready_to_capture  out  1  idle or done
- capture_done  out  1  all segments filled
- cur_seg  out  log2(NUM_SEGMENTS) (min 1)  segment being filled
- rd_data  out  DATA_WIDTH  buffer read data
- trig_addr  out  ADDR_WIDTH  absolute address of trigger sample of rd_seg

Function
REQ-005 SEG_DEPTH SHALL equal 2^ADDR_WIDTH / NUM_SEGMENTS; segment s SHALL occupy addresses s*SEG_DEPTH .. s*SEG_DEPTH+SEG_DEPTH-1.
REQ-006 States SHALL be IDLE, PRE, WAIT_TRIG, POST, DONE; no state transition and no write SHALL occur in a cycle with clk_enable=0, except abort and reset.
REQ-007 IDLE/DONE + start=1 + clk_enable=1: latch P = min(pretrig_depth, SEG_DEPTH-1), seg=0, offset=0, count=0; go PRE if P>0, else WAIT_TRIG.
REQ-008 PRE: write data_in at seg base+offset each enabled cycle; trigger ignored; after the P-th write go WAIT_TRIG.
REQ-009 WAIT_TRIG: write each enabled cycle; offset wraps modulo SEG_DEPTH; the sample written with trigger=1 SHALL be the trigger sample, its address stored for seg; go POST with count = SEG_DEPTH-1-P.
REQ-010 POST: write each enabled cycle, decrementing count; on the write that makes count zero go to PRE/WAIT_TRIG for seg+1 (offset=0, same P), or to DONE if seg=NUM_SEGMENTS-1.
REQ-011 If P=SEG_DEPTH-1, the trigger write itself SHALL complete the segment, with no POST cycle.
REQ-012 Each completed segment SHALL hold P samples preceding the trigger, the trigger sample, and SEG_DEPTH-1-P following samples, contiguous modulo SEG_DEPTH.
REQ-013 start SHALL be ignored in PRE, WAIT_TRIG and POST.
REQ-014 abort=1 SHALL force IDLE on the next edge regardless of clk_enable; capture_done=0; buffer contents retained; abort wins over simultaneous start.
REQ-015 ready_to_capture SHALL be 1 in IDLE and DONE, else 0; capture_done SHALL be 1 only in DONE and clear when start re-arms.
REQ-016 rd_data SHALL return buffer[rd_addr] one clk later, independent of clk_enable; a read of the address being written SHALL return the old data.
REQ-017 trig_addr SHALL be a combinational lookup of the stored trigger address for rd_seg, 0 if never triggered since reset.

Reset
REQ-018 reset SHALL give state=IDLE, ready_to_capture=1, capture_done=0, cur_seg=0, all trigger addresses=0, rd_data=0; buffer RAM contents undefined, not cleared.
REQ-019 reset mid-capture SHALL take effect on the next edge and override start and abort.

Structure
REQ-020 State encoding and SEG_DEPTH/log2 helper functions SHALL live in shared package capture_pkg.
REQ-021 Storage SHALL be one sub-module capture_ram: simple dual-port, one write port, registered read port, 2^ADDR_WIDTH x DATA_WIDTH.

Verification (DATA_WIDTH=8, ADDR_WIDTH=4, NUM_SEGMENTS=2, SEG_DEPTH=8, data_in = cycle counter)
REQ-022 The bench SHALL cover: pretrig_depth=3, trigger on the 6th enabled sample -> segment 0 holds samples 2..9, trig_addr(rd_seg=0)=5.
REQ-023 The bench SHALL cover: pretrig_depth=3, trigger asserted during PRE then deasserted -> trigger ignored, segment 0 waits for a WAIT_TRIG trigger.
REQ-024 The bench SHALL cover: pretrig_depth=9 -> P clamps to 7; segment completes on the trigger write; second segment arms without a start.
REQ-025 The bench SHALL cover: WAIT_TRIG held for 12 samples before trigger -> offset wraps, trigger stored at seg base+((P+12) mod 8).
REQ-026 The bench SHALL cover: abort in POST with start high in the same cycle -> next cycle IDLE, ready_to_capture=1, capture_done=0.
REQ-027 The bench SHALL cover: clk_enable low every other cycle -> writes occur only on enabled cycles and buffer contents equal the enabled-only sequence.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the segmented capture controller: state codes and
// sizing helpers used by both the controller and the testbench.
package capture_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_PRE       = 3'd1;
   localparam logic [2:0] ST_WAIT_TRIG = 3'd2;
   localparam logic [2:0] ST_POST      = 3'd3;
   localparam logic [2:0] ST_DONE      = 3'd4;

   function automatic int log2_ceil(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // Select fields still need one bit when there is only a single segment.
   function automatic int log2_min1(input int n);
      return (n <= 1) ? 1 : log2_ceil(n);
   endfunction

   function automatic int seg_depth(input int addr_width, input int num_segments);
      return (1 << addr_width) / num_segments;
   endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port
// with read-before-write behaviour on an address collision.
module capture_ram #(
   parameter int DATA_WIDTH = 72,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // The array itself is never reset so it can map onto block RAM; only the
   // output register clears.
   always_ff @(posedge clk) begin
      if (reset) rd_data <= '0;
      else       rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/capture_segment_ctrl.sv
// Segmented pre/post-trigger capture controller: fills NUM_SEGMENTS equal
// slices of one buffer, each centred on its own trigger sample.
module capture_segment_ctrl
   import capture_pkg::*;
#(
   parameter int DATA_WIDTH   = 72,
   parameter int ADDR_WIDTH   = 12,
   parameter int NUM_SEGMENTS = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 clk_enable,
   input  logic                                 start,
   input  logic                                 abort,
   input  logic [ADDR_WIDTH-1:0]                pretrig_depth,
   input  logic                                 trigger,
   input  logic [DATA_WIDTH-1:0]                data_in,
   input  logic [ADDR_WIDTH-1:0]                rd_addr,
   input  logic [log2_min1(NUM_SEGMENTS)-1:0]   rd_seg,
   output logic                                 ready_to_capture,
   output logic                                 capture_done,
   output logic [log2_min1(NUM_SEGMENTS)-1:0]   cur_seg,
   output logic [DATA_WIDTH-1:0]                rd_data,
   output logic [ADDR_WIDTH-1:0]                trig_addr
);

   localparam int SEG_BITS     = log2_min1(NUM_SEGMENTS);
   localparam int SEG_SHIFT    = ADDR_WIDTH - log2_ceil(NUM_SEGMENTS);
   localparam int SEG_DEPTH    = seg_depth(ADDR_WIDTH, NUM_SEGMENTS);
   localparam int TRIG_ENTRIES = 2**SEG_BITS;
   localparam logic [ADDR_WIDTH-1:0] OFF_MAX  = ADDR_WIDTH'(SEG_DEPTH - 1);
   localparam logic [SEG_BITS-1:0]   LAST_SEG = SEG_BITS'(NUM_SEGMENTS - 1);

   logic [2:0]            state_q;
   logic [SEG_BITS-1:0]   seg_q;
   logic [ADDR_WIDTH-1:0] offset_q;
   logic [ADDR_WIDTH-1:0] pre_q;
   logic [ADDR_WIDTH-1:0] count_q;
   logic [ADDR_WIDTH-1:0] trig_q [TRIG_ENTRIES];

   logic [ADDR_WIDTH-1:0] p_clamped;
   logic [ADDR_WIDTH-1:0] offset_inc;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  capturing;
   logic                  wr_en;
   logic                  seg_done;
   logic [2:0]            next_seg_state;

   assign p_clamped  = (pretrig_depth > OFF_MAX) ? OFF_MAX : pretrig_depth;
   assign offset_inc = (offset_q == OFF_MAX) ? '0 : offset_q + ADDR_WIDTH'(1);
   assign wr_addr    = (ADDR_WIDTH'(seg_q) << SEG_SHIFT) + offset_q;
   assign capturing  = (state_q == ST_PRE) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
   assign wr_en      = capturing && clk_enable && !abort && !reset;

   // A segment closes either on its trigger write (no post-trigger room) or
   // on the last post-trigger write.
   assign seg_done = ((state_q == ST_WAIT_TRIG) && trigger && (pre_q == OFF_MAX)) ||
                     ((state_q == ST_POST) && (count_q == ADDR_WIDTH'(1)));
   assign next_seg_state = (seg_q == LAST_SEG) ? ST_DONE :
                           ((pre_q != '0) ? ST_PRE : ST_WAIT_TRIG);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         seg_q    <= '0;
         offset_q <= '0;
         pre_q    <= '0;
         count_q  <= '0;
         for (int i = 0; i < TRIG_ENTRIES; i++) trig_q[i] <= '0;
      end else if (abort) begin
         state_q <= ST_IDLE;
      end else if (clk_enable) begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  pre_q    <= p_clamped;
                  seg_q    <= '0;
                  offset_q <= '0;
                  count_q  <= '0;
                  state_q  <= (p_clamped != '0) ? ST_PRE : ST_WAIT_TRIG;
               end
            end
            ST_PRE: begin
               offset_q <= offset_inc;
               if (offset_inc == pre_q) state_q <= ST_WAIT_TRIG;
            end
            ST_WAIT_TRIG: begin
               offset_q <= offset_inc;
               if (trigger) begin
                  trig_q[seg_q] <= wr_addr;
                  count_q       <= OFF_MAX - pre_q;
                  state_q       <= ST_POST;
               end
            end
            ST_POST: begin
               offset_q <= offset_inc;
               count_q  <= count_q - ADDR_WIDTH'(1);
            end
            default: state_q <= ST_IDLE;
         endcase
         // Segment hand-over overrides the per-state updates above.
         if (seg_done) begin
            state_q  <= next_seg_state;
            offset_q <= '0;
            if (seg_q != LAST_SEG) seg_q <= seg_q + SEG_BITS'(1);
         end
      end
   end

   assign ready_to_capture = (state_q == ST_IDLE) || (state_q == ST_DONE);
   assign capture_done     = (state_q == ST_DONE);
   assign cur_seg          = seg_q;
   assign trig_addr        = trig_q[rd_seg];

   capture_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_ram (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(data_in),
      .rd_addr(rd_addr),
      .rd_data(rd_data)
   );

endmodule

// File: tb/tb_capture_segment_ctrl.sv
// Self-checking bench for capture_segment_ctrl: write-count based reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_capture_segment_ctrl;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NS = 2;
   localparam int SD = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          clk_enable;
   logic          start;
   logic          abort;
   logic [AW-1:0] pretrig_depth;
   logic          trigger;
   logic [DW-1:0] data_in;
   logic [AW-1:0] rd_addr;
   logic [0:0]    rd_seg;
   logic          ready_to_capture;
   logic          capture_done;
   logic [0:0]    cur_seg;
   logic [DW-1:0] rd_data;
   logic [AW-1:0] trig_addr;

   logic [7:0] cycle = 8'd0;
   int n_checks = 0;
   int n_fails  = 0;

   capture_segment_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .NUM_SEGMENTS(NS)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .clk_enable      (clk_enable),
      .start           (start),
      .abort           (abort),
      .pretrig_depth   (pretrig_depth),
      .trigger         (trigger),
      .data_in         (data_in),
      .rd_addr         (rd_addr),
      .rd_seg          (rd_seg),
      .ready_to_capture(ready_to_capture),
      .capture_done    (capture_done),
      .cur_seg         (cur_seg),
      .rd_data         (rd_data),
      .trig_addr       (trig_addr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 8'd1;
   assign data_in = cycle;

   // Reference model: a segment is just a count of writes n; write n lands at
   // base + n mod SD, and the segment closes SD-P writes after the trigger write.
   bit model_live = 1'b0;
   bit m_active, m_done;
   int m_seg, m_p, m_n, m_tidx;
   int m_trig [NS];
   int m_mem [2**AW];
   bit m_known [2**AW];
   int m_rd;
   bit m_rd_valid;

   always @(posedge clk) begin
      int addr;
      if (reset) begin
         model_live = 1'b1;
         m_active = 1'b0;
         m_done = 1'b0;
         m_seg = 0;
         for (int i = 0; i < NS; i++) m_trig[i] = 0;
         m_rd = 0;
         m_rd_valid = 1'b1;
      end else begin
         m_rd_valid = m_known[rd_addr];
         m_rd = m_mem[rd_addr];
         if (abort) begin
            m_active = 1'b0;
            m_done = 1'b0;
         end else if (clk_enable) begin
            if (!m_active) begin
               if (start) begin
                  m_p = (int'(pretrig_depth) > SD - 1) ? SD - 1 : int'(pretrig_depth);
                  m_seg = 0;
                  m_n = 0;
                  m_tidx = -1;
                  m_active = 1'b1;
                  m_done = 1'b0;
               end
            end else begin
               addr = m_seg * SD + (m_n % SD);
               m_mem[addr] = int'(data_in);
               m_known[addr] = 1'b1;
               if (m_tidx < 0 && m_n >= m_p && trigger) begin
                  m_tidx = m_n;
                  m_trig[m_seg] = addr;
               end
               m_n++;
               if (m_tidx >= 0 && m_n == m_tidx + SD - m_p) begin
                  if (m_seg == NS - 1) begin
                     m_active = 1'b0;
                     m_done = 1'b1;
                  end else begin
                     m_seg++;
                     m_n = 0;
                     m_tidx = -1;
                  end
               end
            end
         end
      end
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_live) begin
         checkOutput("ready_to_capture", int'(ready_to_capture), int'(!m_active));
         checkOutput("capture_done", int'(capture_done), int'(m_done));
         checkOutput("cur_seg", int'(cur_seg), m_seg);
         checkOutput("trig_addr", int'(trig_addr), m_trig[rd_seg]);
         if (m_rd_valid) checkOutput("rd_data", int'(rd_data), m_rd);
      end
   end

   task automatic applyStimulus(input logic st, input logic ab, input logic en, input logic tr);
      start = st;
      abort = ab;
      clk_enable = en;
      trigger = tr;
      @(posedge clk);
      #1;
   endtask

   task automatic waitReady(input int budget, input string name);
      int spent;
      spent = 0;
      while (!ready_to_capture && spent < budget) begin
         applyStimulus(1'b0, 1'b0, 1'b1, ($urandom_range(0, 3) == 0));
         spent++;
      end
      checkOutput(name, int'(ready_to_capture), 1);
   endtask

   initial begin
      logic [7:0] d0;
      int enq[$];
      int expv;

      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      clk_enable = 1'b1;
      trigger = 1'b0;
      pretrig_depth = '0;
      rd_addr = '0;
      rd_seg = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_ready", int'(ready_to_capture), 1);
      checkOutput("reset_done", int'(capture_done), 0);
      checkOutput("reset_cur_seg", int'(cur_seg), 0);
      checkOutput("reset_trig_addr", int'(trig_addr), 0);
      checkOutput("reset_rd_data", int'(rd_data), 0);
      reset = 1'b0;

      // Pre-trigger 3, trigger on the 6th sample: segment 0 keeps samples 2..9.
      pretrig_depth = 4'd3;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      d0 = data_in;
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("s1_trig_addr", int'(trig_addr), 5);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("s1_cur_seg_advanced", int'(cur_seg), 1);
      checkOutput("s1_busy", int'(ready_to_capture), 0);
      waitReady(200, "s1_wait_ready");
      checkOutput("s1_done", int'(capture_done), 1);
      for (int k = 0; k < SD; k++) begin
         rd_addr = AW'(k);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         expv = (int'(d0) + k + ((k < 2) ? 8 : 0)) & 255;
         checkOutput("s1_seg0_contents", int'(rd_data), expv);
      end
      rd_addr = '0;

      // Trigger held through PRE must be ignored; the real one lands at offset 6.
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
      checkOutput("s2_done_cleared", int'(capture_done), 0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("s2_pre_trigger_ignored", int'(trig_addr), 5);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("s2_trig_addr", int'(trig_addr), 6);

      // Abort wins over start while in POST.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      checkOutput("s3_abort_ready", int'(ready_to_capture), 1);
      checkOutput("s3_abort_done", int'(capture_done), 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("s3_stays_idle", int'(ready_to_capture), 1);

      // pretrig 9 clamps to 7; then a 12-sample wait wraps the offset.
      pretrig_depth = 4'd9;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("s4_seg0_trig", int'(trig_addr), 7);
      checkOutput("s4_auto_rearm_seg", int'(cur_seg), 1);
      checkOutput("s4_auto_rearm_busy", int'(ready_to_capture), 0);
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      rd_seg = 1'b1;
      #1;
      checkOutput("s4_seg1_wrapped_trig", int'(trig_addr), 11);
      checkOutput("s4_done", int'(capture_done), 1);
      rd_seg = 1'b0;

      // Every other cycle disabled (with trigger high): only enabled samples land.
      pretrig_depth = 4'd2;
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
         enq.push_back(int'(data_in));
         applyStimulus(1'b0, 1'b0, 1'b1, (i == 5));
      end
      checkOutput("s5_trig_addr", int'(trig_addr), 5);
      checkOutput("s5_cur_seg", int'(cur_seg), 1);
      waitReady(200, "s5_wait_ready");
      for (int k = 0; k < SD; k++) begin
         rd_addr = AW'(k);
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
         expv = (k + 8 <= 10) ? enq[k + 8] : enq[k];
         checkOutput("s5_enabled_only_contents", int'(rd_data), expv);
      end

      // Randomized traffic, including occasional mid-capture resets.
      for (int i = 0; i < 2000; i++) begin
         pretrig_depth = AW'($urandom_range(0, 15));
         rd_addr = AW'($urandom_range(0, 15));
         rd_seg = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 199) == 0) begin
            reset = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            reset = 1'b0;
         end else begin
            applyStimulus(($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
         end
      end

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
